siso_frame_rx: RTL and testbench
================================

# siso_frame_rx

Serial frame receiver that sits directly downstream of the `siso` shift register and consumes its one-bit-per-clock `q` stream. It hunts for a sync word, then deserializes a fixed number of data words MSB-first. Each word is presented on a single-entry valid/ready output register. After the last word of the frame it returns to hunting.

## Interface

Parameters:
- `WIDTH`, 8: bits per sync word and per data word (≥ 2).
- `SYNC`, 8'hA5: sync pattern, `WIDTH` bits. Any value is legal, including 0.
- `FRAME_WORDS`, 2: data words per frame (≥ 1).

Ports:
- `clock` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high. Sampled on the rising edge of `clock`.
- `d` in 1: serial bit. Sampled on every rising edge (no enable). Connects to `siso.q`.
- `out_ready` in 1: consumer accepts `out_data` this cycle.
- `out_data` out WIDTH: last completed data word.
- `out_valid` out 1: `out_data` holds an unconsumed word.
- `in_sync` out 1: high while in state DATA.
- `overflow` out 1: sticky flag. A completed word was dropped because the output register was full.

## Operation

Reset state (after a reset edge):
- `out_data` = 0, `out_valid` = 0, `in_sync` = 0, `overflow` = 0.
- State = HUNT. All counters and shift registers = 0.

States:
- **HUNT**
  - Each edge: `win <= {win[WIDTH-2:0], d}`; `fill` increments, saturating at `WIDTH`.
  - Match condition is `{win[WIDTH-2:0], d} == SYNC` together with `fill >= WIDTH-1`, so the comparison only covers `WIDTH` freshly sampled bits.
  - On that edge: state <= DATA, `bitcnt` <= 0, `wordcnt` <= 0.
  - Matching is sliding. Overlapping and partial patterns are retried on every bit.
- **DATA**
  - Each edge: `sh <= {sh[WIDTH-2:0], d}`; `bitcnt` increments.
  - On the edge that samples bit `WIDTH-1`, the word is complete: `word = {sh[WIDTH-2:0], d}`.
    - If `out_valid`=0, or `out_valid`=1 with `out_ready`=1 on the same edge: `out_data` <= word, `out_valid` <= 1.
    - Otherwise: the word is dropped and `overflow` <= 1. `out_data` is unchanged.
    - `bitcnt` <= 0 and `wordcnt` increments.
  - If `wordcnt == FRAME_WORDS-1` on the completion edge: state <= HUNT, `fill` <= 0, `win` <= 0.

Output handshake, independent of state:
- `out_valid`=1 with `out_ready`=1 at an edge: the word is consumed and `out_valid` <= 0, unless a new word loads on the same edge, in which case `out_valid` stays 1 with the new data.
- `out_ready` while `out_valid`=0 is ignored.
- `out_data` is held stable while `out_valid`=1 and not consumed.

Other rules:
- `overflow` clears only on reset.
- Reset mid-frame discards the partial word and the frame. A full new sync is required afterwards.

## Timing

- Sync latency: `in_sync` rises the cycle after the edge that samples the last sync bit.
- The first data bit is sampled on the next edge; there is no gap bit.
- Word latency: `out_valid` rises the cycle after the edge sampling the word's last bit.
- Frame length without the macro: WIDTH + FRAME_WORDS×WIDTH bit-cycles.
- `in_sync` falls the cycle after the last data bit is sampled. Hunting resumes with that next bit.
- Back-to-back frames need no idle bits.
- Throughput: one word per WIDTH cycles. The consumer must accept within WIDTH cycles of `out_valid` rising to avoid overflow.

## Configuration

`SISO_FRAME_PARITY_EN`

Defined:
- Each data word is followed by one even-parity bit, so the XOR of the word and the parity bit is 0.
- The word-completion actions move to the parity edge, and the per-word period becomes WIDTH+1.
- Adds output `parity_err` (out, 1, sticky, reset 0).
- On a parity mismatch: the word is dropped, `parity_err` <= 1, and `out_valid` and `overflow` are unaffected. The frame continues.

Undefined:
- No parity bit and no `parity_err` port; behaviour is as above.

## Test plan

Parameters: WIDTH=8, SYNC=8'hA5, FRAME_WORDS=2.

1. Reset held 2 cycles, `d` toggling → `out_valid`=0, `in_sync`=0, `overflow`=0, `out_data`=0 throughout.
2. Bits 1,0,1 then A5, 3C, C3 with `out_ready`=1 → `in_sync` rises 1 cycle after the A5 LSB. `out_data`=3C valid for 1 cycle, then C3 8 cycles later. `in_sync` falls after the C3 LSB.
3. Stream 0xA, 0xA5 (overlapping 1010 prefix), then 11, 22 → sync found once at the true A5 boundary; outputs 11 then 22.
4. A5, 55, AA with `out_ready`=0 → `out_data`=55 held, AA dropped, `overflow`=1. Raising `out_ready` then gives one handshake and `out_valid`=0.
5. A5, then 4 data bits, then a reset pulse, then A5, 81, 7E → no output from the aborted frame; 81 then 7E after the resync.
6. With `SISO_FRAME_PARITY_EN`: A5, 03+p0, 07+p0 → 03 accepted. 07 (odd weight, bad parity) is dropped, `parity_err`=1, `out_valid` stays 0 after 03 is consumed.

Source files
------------

// File: rtl/siso_frame_rx.sv
// siso_frame_rx
// Serial frame receiver fed by the one-bit-per-clock q stream of a siso shift
// register. It hunts for a WIDTH-bit sync word and then deserializes
// FRAME_WORDS data words MSB-first. After the last word it goes back to hunting.
//
// Parameters
//   WIDTH       bits per sync word and per data word (>= 2)
//   SYNC        sync pattern, WIDTH bits (any value, including 0)
//   FRAME_WORDS data words per frame (>= 1)
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   d          serial input bit, sampled on every edge
//   out_ready  consumer accepts out_data this cycle
//   out_data   last completed data word
//   out_valid  out_data holds an unconsumed word
//   in_sync    high while the receiver is inside a frame (state DATA)
//   overflow   sticky: a completed word was dropped because the output was full
//   parity_err sticky: a word failed its even-parity check (parity build only)
//
// Build option
//   SISO_FRAME_PARITY_EN  each data word is followed by one even-parity bit.
//                         Words complete on that parity edge, and a word that
//                         fails the check is dropped and sets parity_err.
//
// Output handshake: out_data/out_valid form a single-entry register. A word
// transfers on any rising edge where out_valid=1 and out_ready=1. out_ready is
// ignored while out_valid=0. out_data is held stable while out_valid=1 and the
// word has not been consumed. When a new word completes on the same edge that
// consumes the old one, the new word replaces it and out_valid stays high.
module siso_frame_rx #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] SYNC        = 8'hA5,
  parameter int               FRAME_WORDS = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             d,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             in_sync,
  output logic             overflow
`ifdef SISO_FRAME_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int WC_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
`ifdef SISO_FRAME_PARITY_EN
  localparam int BIT_LAST = WIDTH;      // index of the parity bit
`else
  localparam int BIT_LAST = WIDTH - 1;  // index of the word's last data bit
`endif

  localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] FILL_MIN  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(BIT_LAST);
  localparam logic [WC_W-1:0]  WORD_END  = WC_W'(FRAME_WORDS - 1);

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  state_t state, state_next;

  // The hunt window keeps only WIDTH-1 past bits. The incoming bit d supplies
  // the newest bit of the comparison.
  logic [WIDTH-2:0] win;
  logic [WIDTH-1:0] win_shift;
  logic [CNT_W-1:0] fill;
  logic [CNT_W-1:0] bitcnt;
  logic [WC_W-1:0]  wordcnt;

  logic [WIDTH-1:0] word;
  logic             word_ok;

`ifdef SISO_FRAME_PARITY_EN
  // With parity, the full word has been shifted in by the time the parity bit
  // arrives. The check passes when the XOR over the word and d is 0.
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_next;
  assign word    = sh;
  assign sh_next = {sh[WIDTH-2:0], d};
  assign word_ok = ~(^sh ^ d);
`else
  // Without parity, the word's last bit is d itself, so only WIDTH-1 bits
  // need to be stored.
  logic [WIDTH-2:0] sh;
  logic [WIDTH-2:0] sh_next;
  assign word    = {sh, d};
  assign sh_next = word[WIDTH-2:0];
  assign word_ok = 1'b1;
`endif

  assign win_shift = {win, d};
  assign in_sync   = (state == DATA);

  logic sync_hit;
  logic word_done;
  logic frame_done;
  logic load;
  logic drop;

  always_comb begin
    state_next = state;
    sync_hit   = 1'b0;
    word_done  = 1'b0;
    frame_done = 1'b0;
    case (state)
      HUNT: begin
        // The fill gate stops stale zeros from after reset or a frame end
        // from matching a SYNC that contains zeros.
        if ((win_shift == SYNC) && (fill >= FILL_MIN)) begin
          sync_hit   = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bitcnt == BIT_END) begin
          word_done = 1'b1;
          if (wordcnt == WORD_END) begin
            frame_done = 1'b1;
            state_next = HUNT;
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  assign load = word_done & word_ok & (~out_valid | out_ready);
  assign drop = word_done & word_ok & out_valid & ~out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= HUNT;
      win       <= '0;
      fill      <= '0;
      sh        <= '0;
      bitcnt    <= '0;
      wordcnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
`ifdef SISO_FRAME_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        HUNT: begin
          win <= win_shift[WIDTH-2:0];
          if (fill != FILL_FULL) fill <= fill + CNT_W'(1);
          if (sync_hit) begin
            bitcnt  <= '0;
            wordcnt <= '0;
          end
        end
        DATA: begin
          sh <= sh_next;
          if (word_done) begin
            bitcnt  <= '0;
            wordcnt <= wordcnt + WC_W'(1);
          end else begin
            bitcnt <= bitcnt + CNT_W'(1);
          end
          if (frame_done) begin
            fill <= '0;
            win  <= '0;
          end
        end
        default: ;
      endcase

      if (load) begin
        out_data  <= word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (drop) overflow <= 1'b1;
`ifdef SISO_FRAME_PARITY_EN
      if (word_done && !word_ok) parity_err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_siso_frame_rx.sv
// Testbench for siso_frame_rx (WIDTH=8, SYNC=8'hA5, FRAME_WORDS=2).
// Inputs change on the falling edge. The task checks run at that same falling
// edge, so they see the state left by the preceding rising edge. A monitor
// logs every handshake into got_q. Each test compares got_q with its own
// expected queue.
module tb_siso_frame_rx;
  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             d;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             in_sync;
  logic             overflow;
`ifdef SISO_FRAME_PARITY_EN
  logic             parity_err;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got_q[$];

  siso_frame_rx #(.WIDTH(8), .SYNC(8'hA5), .FRAME_WORDS(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .d         (d),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .in_sync   (in_sync),
    .overflow  (overflow)
`ifdef SISO_FRAME_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Handshake monitor: samples just after the falling edge. At that point the
  // inputs for the next rising edge are already stable.
  always @(negedge clock) begin
    #1;
    if (!reset && out_valid && out_ready) got_q.push_back(out_data);
  end

  // driver tasks
  task automatic drive_bit(input logic b);
    d = b;
    @(negedge clock);
  endtask

  task automatic drive_word(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) drive_bit(w[i]);
  endtask

  task automatic drive_data_word(input logic [WIDTH-1:0] w);
    drive_word(w);
`ifdef SISO_FRAME_PARITY_EN
    drive_bit(^w);
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_bit(i[0]);
      if (out_valid !== 1'b0) begin n_mismatched++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_compared++;
      if (in_sync !== 1'b0) begin n_mismatched++; $display("FAIL reset_in_sync: got %b expected 0", in_sync); end
      n_compared++;
      if (overflow !== 1'b0) begin n_mismatched++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      n_compared++;
      if (out_data !== 8'h00) begin n_mismatched++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
      n_compared++;
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] e, g;
    out_ready = 1'b1;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    w = 8'hA5;
    for (int i = WIDTH - 1; i >= 1; i--) drive_bit(w[i]);
    if (in_sync !== 1'b0) begin n_mismatched++; $display("FAIL basic_sync_early: in_sync=%b expected 0", in_sync); end
    n_compared++;
    drive_bit(w[0]);
    if (in_sync !== 1'b1) begin n_mismatched++; $display("FAIL basic_sync_rise: in_sync=%b expected 1", in_sync); end
    n_compared++;
    drive_data_word(8'h3C);
    if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
      n_mismatched++; $display("FAIL basic_word0: valid=%b data=%h expected 1/3c", out_valid, out_data);
    end
    n_compared++;
    if (in_sync !== 1'b1) begin n_mismatched++; $display("FAIL basic_mid_frame_sync: in_sync=%b expected 1", in_sync); end
    n_compared++;
    w = 8'hC3;
    drive_bit(w[7]);
    if (out_valid !== 1'b0) begin n_mismatched++; $display("FAIL basic_word0_one_cycle: valid=%b expected 0", out_valid); end
    n_compared++;
    for (int i = WIDTH - 2; i >= 0; i--) drive_bit(w[i]);
`ifdef SISO_FRAME_PARITY_EN
    drive_bit(^w);
`endif
    if (out_valid !== 1'b1 || out_data !== 8'hC3) begin
      n_mismatched++; $display("FAIL basic_word1: valid=%b data=%h expected 1/c3", out_valid, out_data);
    end
    n_compared++;
    if (in_sync !== 1'b0) begin n_mismatched++; $display("FAIL basic_sync_fall: in_sync=%b expected 0", in_sync); end
    n_compared++;
    drive_bit(1'b0);
    if (out_valid !== 1'b0) begin n_mismatched++; $display("FAIL basic_drain: valid=%b expected 0", out_valid); end
    n_compared++;
    if (got_q.size() != exp_q.size()) begin
      n_mismatched++; $display("FAIL basic_count: got %0d words expected %0d", got_q.size(), exp_q.size());
    end
    n_compared++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin n_mismatched++; $display("FAIL basic_word: got %h expected %h", g, e); end
      n_compared++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overlap();
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] e, g;
    logic seen;
    out_ready = 1'b1;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    seen = 1'b0;
    drive_bit(1'b1); seen |= in_sync;
    drive_bit(1'b0); seen |= in_sync;
    drive_bit(1'b1); seen |= in_sync;
    drive_bit(1'b0); seen |= in_sync;
    w = 8'hA5;
    for (int i = WIDTH - 1; i >= 1; i--) begin drive_bit(w[i]); seen |= in_sync; end
    if (seen !== 1'b0) begin n_mismatched++; $display("FAIL overlap_false_sync: seen=%b expected 0", seen); end
    n_compared++;
    drive_bit(w[0]);
    if (in_sync !== 1'b1) begin n_mismatched++; $display("FAIL overlap_sync: in_sync=%b expected 1", in_sync); end
    n_compared++;
    drive_data_word(8'h11);
    drive_data_word(8'h22);
    drive_bit(1'b0);
    if (got_q.size() != exp_q.size()) begin
      n_mismatched++; $display("FAIL overlap_count: got %0d words expected %0d", got_q.size(), exp_q.size());
    end
    n_compared++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin n_mismatched++; $display("FAIL overlap_word: got %h expected %h", g, e); end
      n_compared++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] e, g;
    out_ready = 1'b0;
    exp_q.push_back(8'h55);
    drive_word(8'hA5);
    drive_data_word(8'h55);
    if (out_valid !== 1'b1 || out_data !== 8'h55 || overflow !== 1'b0) begin
      n_mismatched++; $display("FAIL ovf_first: valid=%b data=%h ovf=%b expected 1/55/0", out_valid, out_data, overflow);
    end
    n_compared++;
    w = 8'hAA;
    for (int i = WIDTH - 1; i >= 4; i--) drive_bit(w[i]);
    if (out_data !== 8'h55) begin n_mismatched++; $display("FAIL ovf_hold_mid: data=%h expected 55", out_data); end
    n_compared++;
    for (int i = 3; i >= 0; i--) drive_bit(w[i]);
`ifdef SISO_FRAME_PARITY_EN
    drive_bit(^w);
`endif
    if (out_valid !== 1'b1 || out_data !== 8'h55) begin
      n_mismatched++; $display("FAIL ovf_hold: valid=%b data=%h expected 1/55", out_valid, out_data);
    end
    n_compared++;
    if (overflow !== 1'b1) begin n_mismatched++; $display("FAIL ovf_flag: overflow=%b expected 1", overflow); end
    n_compared++;
    out_ready = 1'b1;
    drive_bit(1'b0);
    if (out_valid !== 1'b0) begin n_mismatched++; $display("FAIL ovf_drain: valid=%b expected 0", out_valid); end
    n_compared++;
    if (overflow !== 1'b1) begin n_mismatched++; $display("FAIL ovf_sticky: overflow=%b expected 1", overflow); end
    n_compared++;
    if (got_q.size() != exp_q.size()) begin
      n_mismatched++; $display("FAIL ovf_count: got %0d words expected %0d", got_q.size(), exp_q.size());
    end
    n_compared++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin n_mismatched++; $display("FAIL ovf_word: got %h expected %h", g, e); end
      n_compared++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_abort();
    logic [WIDTH-1:0] e, g;
    out_ready = 1'b1;
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h7E);
    drive_word(8'hA5);
    if (in_sync !== 1'b1) begin n_mismatched++; $display("FAIL abort_sync: in_sync=%b expected 1", in_sync); end
    n_compared++;
    drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1);
    reset = 1'b1;
    drive_bit(1'b0);
    reset = 1'b0;
    if (in_sync !== 1'b0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      n_mismatched++; $display("FAIL abort_reset: sync=%b valid=%b ovf=%b expected 0/0/0", in_sync, out_valid, overflow);
    end
    n_compared++;
    drive_word(8'hA5);
    drive_data_word(8'h81);
    drive_data_word(8'h7E);
    drive_bit(1'b0);
    if (overflow !== 1'b0) begin n_mismatched++; $display("FAIL abort_ovf: overflow=%b expected 0", overflow); end
    n_compared++;
    if (got_q.size() != exp_q.size()) begin
      n_mismatched++; $display("FAIL abort_count: got %0d words expected %0d", got_q.size(), exp_q.size());
    end
    n_compared++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin n_mismatched++; $display("FAIL abort_word: got %h expected %h", g, e); end
      n_compared++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] e, g;
    out_ready = 1'b1;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    drive_word(8'hA5);
    drive_data_word(8'h11);
    drive_data_word(8'h22);
    drive_word(8'hA5);
    if (in_sync !== 1'b1) begin n_mismatched++; $display("FAIL b2b_resync: in_sync=%b expected 1", in_sync); end
    n_compared++;
    drive_data_word(8'h33);
    drive_data_word(8'h44);
    drive_bit(1'b0);
    if (got_q.size() != exp_q.size()) begin
      n_mismatched++; $display("FAIL b2b_count: got %0d words expected %0d", got_q.size(), exp_q.size());
    end
    n_compared++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin n_mismatched++; $display("FAIL b2b_word: got %h expected %h", g, e); end
      n_compared++;
    end
    exp_q.delete(); got_q.delete();
  endtask

`ifdef SISO_FRAME_PARITY_EN
  task automatic test_parity();
    logic [WIDTH-1:0] e, g;
    out_ready = 1'b1;
    exp_q.push_back(8'h03);
    drive_word(8'hA5);
    drive_word(8'h03); drive_bit(1'b0);
    if (out_valid !== 1'b1 || out_data !== 8'h03 || parity_err !== 1'b0) begin
      n_mismatched++; $display("FAIL par_good: valid=%b data=%h perr=%b expected 1/03/0", out_valid, out_data, parity_err);
    end
    n_compared++;
    drive_word(8'h07); drive_bit(1'b0);
    if (parity_err !== 1'b1) begin n_mismatched++; $display("FAIL par_err: parity_err=%b expected 1", parity_err); end
    n_compared++;
    if (out_valid !== 1'b0 || overflow !== 1'b0 || in_sync !== 1'b0) begin
      n_mismatched++; $display("FAIL par_drop: valid=%b ovf=%b sync=%b expected 0/0/0", out_valid, overflow, in_sync);
    end
    n_compared++;
    if (got_q.size() != exp_q.size()) begin
      n_mismatched++; $display("FAIL par_count: got %0d words expected %0d", got_q.size(), exp_q.size());
    end
    n_compared++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin n_mismatched++; $display("FAIL par_word: got %h expected %h", g, e); end
      n_compared++;
    end
    exp_q.delete(); got_q.delete();
  endtask
`endif

  initial begin
    reset     = 1'b1;
    d         = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_overlap();
    test_overflow();
    test_reset_abort();
    test_back_to_back();
`ifdef SISO_FRAME_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
